// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one operand bit per cycle, LSB first,
// valid/ready handshakes on both the operand and the result side.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  res_sr;
    logic [WIDTH-1:0]  res_next;
    logic [CW-1:0]     cnt;
    logic              br;
    logic              diff_bit;
    logic              br_next;

    fs u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (diff_bit),
        .bout (br_next)
    );

    // Result fills from the MSB; written as a shift so WIDTH=1 needs no special case.
    always_comb begin
        res_next = (res_sr >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        res_sr   <= '0;
                        br       <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    if (cnt == LAST) begin
                        d         <= res_next;
                        bout      <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
